// File: rtl/jk_pkg.sv
// Shared JK flip-flop excitation encodings, ordered as {J, K}.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_e;

endpackage

// File: rtl/jk_mod_counter_if.sv
// Signal bundle for the modulo JK counter: controls from the driver, state and excitations back.
interface jk_mod_counter_if #(
    parameter int W = 4
);

    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] mod_n;
    logic [W-1:0] q;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic         tc;
    logic         err;

    modport master (
        output en, up, load, load_val, mod_n,
        input  q, j_out, k_out, tc, err
    );

    modport slave (
        input  en, up, load, load_val, mod_n,
        output q, j_out, k_out, tc, err
    );

endinterface

// File: rtl/jk_cell.sv
// Single JK storage bit with synchronous active-high reset.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            case (jk_op_e'({j, k}))
                JK_HOLD: q_q <= q_q;
                JK_CLR:  q_q <= 1'b0;
                JK_SET:  q_q <= 1'b1;
                JK_TGL:  q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-M counter whose bits are JK cells; next state is turned into J/K excitations.
module jk_mod_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] mod_n,
    output logic [W-1:0] q,
    output logic [W-1:0] j_out,
    output logic [W-1:0] k_out,
    output logic         tc,
    output logic         err
);

    localparam logic [W:0] FULL_MOD = {1'b1, {W{1'b0}}};
    localparam logic [W:0] ONE_X    = {{W{1'b0}}, 1'b1};

    logic [W:0]   modEff;
    logic [W:0]   qExt;
    logic [W:0]   ldExt;
    logic [W-1:0] modMax;
    logic [W-1:0] nxt;
    logic         wrap;
    logic         illegal;
    logic         tc_q, tc_d;
    logic         err_q, err_d;

    // Comparisons use one extra bit so a zero modulus can stand for 2^W.
    assign modEff = (mod_n == '0) ? FULL_MOD : {1'b0, mod_n};
    assign qExt   = {1'b0, q};
    assign ldExt  = {1'b0, load_val};
    assign modMax = mod_n - W'(1);

    always_comb begin
        nxt     = q;
        wrap    = 1'b0;
        illegal = 1'b0;
        if (load) begin
            if (ldExt < modEff) begin
                nxt = load_val;
            end else begin
                nxt     = '0;
                illegal = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (qExt + ONE_X >= modEff) begin
                    nxt  = '0;
                    wrap = 1'b1;
                end else begin
                    nxt = q + W'(1);
                end
            end else begin
                if (qExt == '0 || qExt >= modEff) begin
                    nxt  = modMax;
                    wrap = 1'b1;
                end else begin
                    nxt = q - W'(1);
                end
            end
        end
    end

    // Excitations only ever set or clear a changing bit, so J=K=1 cannot appear.
    assign j_out = nxt & ~q;
    assign k_out = ~nxt & q;

    for (genvar i = 0; i < W; i++) begin : g_bit
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_out[i]),
            .k     (k_out[i]),
            .q     (q[i])
        );
    end

    assign tc_d  = wrap;
    assign err_d = illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            tc_q  <= tc_d;
            err_q <= err_d;
        end
    end

    assign tc  = tc_q;
    assign err = err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench: driver pushes model-predicted state per edge, monitor pops and compares.
module tb_jk_mod_counter;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    typedef struct {
        int q;
        bit tc;
        bit err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int   checks   = 0;
    int   failures = 0;
    int   mq       = 0;
    exp_t expQ[$];

    jk_mod_counter_if #(.W(W)) bus ();

    jk_mod_counter #(.W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.en),
        .up       (bus.up),
        .load     (bus.load),
        .load_val (bus.load_val),
        .mod_n    (bus.mod_n),
        .q        (bus.q),
        .j_out    (bus.j_out),
        .k_out    (bus.k_out),
        .tc       (bus.tc),
        .err      (bus.err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus: the model decides the next count from the counter rules.
    task automatic applyStimulus(input bit rst, input bit e, input bit u, input bit ld,
                                 input int lv, input int mn);
        int   m;
        int   nxt;
        bit   wrap;
        bit   bad;
        exp_t x;
        @(negedge clk);
        reset        = rst;
        bus.en       = e;
        bus.up       = u;
        bus.load     = ld;
        bus.load_val = lv[W-1:0];
        bus.mod_n    = mn[W-1:0];
        m    = (mn == 0) ? (1 << W) : mn;
        nxt  = mq;
        wrap = 1'b0;
        bad  = 1'b0;
        if (ld) begin
            if (lv < m) nxt = lv;
            else begin
                nxt = 0;
                bad = 1'b1;
            end
        end else if (e) begin
            if (u) begin
                if (mq >= m - 1) begin
                    nxt  = 0;
                    wrap = 1'b1;
                end else nxt = mq + 1;
            end else begin
                if (mq == 0 || mq >= m) begin
                    nxt  = m - 1;
                    wrap = 1'b1;
                end else nxt = mq - 1;
            end
        end
        #1;
        checkOutput("j_out", int'(bus.j_out), nxt & ~mq & MASK);
        checkOutput("k_out", int'(bus.k_out), ~nxt & mq & MASK);
        x.q   = rst ? 0 : nxt;
        x.tc  = rst ? 1'b0 : wrap;
        x.err = rst ? 1'b0 : bad;
        expQ.push_back(x);
        mq = x.q;
    endtask

    task automatic checkLit(input string name, input int lit);
        @(posedge clk);
        #2;
        checkOutput(name, int'(bus.q), lit);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("q", int'(bus.q), e.q);
                checkOutput("tc", int'(bus.tc), int'(e.tc));
                checkOutput("err", int'(bus.err), int'(e.err));
            end
        end
    end

    initial begin : driver
        bus.en       = 1'b0;
        bus.up       = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.mod_n    = '0;

        applyStimulus(1, 0, 0, 0, 0, 10);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 0, 10);
        checkLit("up_wrap_final", 2);

        applyStimulus(0, 0, 0, 1, 0, 6);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 6);
        checkLit("down_wrap_final", 3);

        applyStimulus(0, 0, 0, 1, 7, 10);
        applyStimulus(0, 0, 0, 1, 12, 10);
        applyStimulus(0, 1, 1, 1, 3, 10);
        checkLit("load_wins", 3);

        applyStimulus(0, 0, 0, 1, 15, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkLit("full_range_down", 15);

        applyStimulus(0, 0, 0, 1, 6, 10);
        applyStimulus(1, 1, 1, 0, 0, 10);
        applyStimulus(0, 1, 1, 0, 0, 10);
        checkLit("after_reset", 1);

        applyStimulus(0, 0, 0, 1, 8, 10);
        applyStimulus(0, 1, 1, 0, 0, 5);
        applyStimulus(0, 0, 0, 1, 8, 10);
        applyStimulus(0, 1, 0, 0, 0, 5);
        checkLit("shrink_down", 4);

        begin
            int mn = 10;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 19) == 0) mn = int'($urandom_range(0, MASK));
                applyStimulus($urandom_range(0, 39) == 0,
                              $urandom_range(0, 3) != 0,
                              $urandom_range(0, 1) == 1,
                              $urandom_range(0, 5) == 0,
                              int'($urandom_range(0, MASK)),
                              mn);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 SHALL have parameter W, default 4, counter width in bits.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port en, input, 1, count enable.
REQ-005 SHALL have port up, input, 1, direction: 1 = up, 0 = down.
REQ-006 SHALL have port load, input, 1, synchronous parallel load request.
REQ-007 SHALL have port load_val, input, W, value to load.
REQ-008 SHALL have port mod_n, input, W, modulus; 0 means 2^W.
REQ-009 SHALL have port q, output, W, current count; each bit is held in a JK cell.
REQ-010 SHALL have port j_out, output, W, J excitation per bit (combinational).
REQ-011 SHALL have port k_out, output, W, K excitation per bit (combinational).
REQ-012 SHALL have port tc, output, 1, registered terminal-count (wrap) pulse.
REQ-013 SHALL have port err, output, 1, registered one-cycle illegal-load flag.

Function
REQ-014 SHALL use effective modulus M = mod_n, or 2^W when mod_n = 0; the legal count range is 0..M-1.
REQ-015 SHALL compute next-state nxt with this priority: load > en > hold.
REQ-016 SHALL set, on load: nxt = load_val if load_val < M, else nxt = 0; direction and en are ignored.
REQ-017 SHALL set, on en & up: nxt = 0 if q >= M-1, else q+1.
REQ-018 SHALL set, on en & ~up: nxt = M-1 if q == 0 or q >= M, else q-1.
REQ-019 SHALL set nxt = q when load = 0 and en = 0.
REQ-020 SHALL drive per bit i: j_out[i] = nxt[i] & ~q[i] and k_out[i] = ~nxt[i] & q[i]; a held bit gives J=K=0, and J=K=1 never occurs.
REQ-021 SHALL update each q bit only through its JK cell on the rising clk edge: 00 hold, 01 clear, 10 set.
REQ-022 SHALL assert tc for exactly one cycle, coincident with the new q, following any edge where en & ~load was true and the step wrapped (up: q >= M-1 to 0; down: q == 0 or q >= M to M-1).
REQ-023 SHALL assert err for exactly one cycle following a load edge with load_val >= M; err SHALL be 0 for all other edges.
REQ-024 SHALL apply mod_n changes immediately to the next computed nxt; an out-of-range q SHALL recover per REQ-017/REQ-018 on the next enabled step.
REQ-025 SHALL compute all arithmetic at W+1 bits internally, so 2^W is representable and no overflow aliasing occurs.

Reset
REQ-026 SHALL force, on a clk edge with reset = 1: q = 0, tc = 0, err = 0.
REQ-027 SHALL give reset priority over load and en.
REQ-028 SHALL still drive j_out and k_out combinationally during reset, from the current q and the non-reset nxt.
REQ-029 SHALL abandon any in-progress count when reset is asserted mid-count; counting resumes from 0 once reset is released.

Structure
REQ-030 SHALL place the JK encoding constants (HOLD=00, CLR=01, SET=10, TGL=11) in shared package jk_pkg.
REQ-031 SHALL instantiate sub-module jk_cell W times (ports clk, reset, j, k, q), one per count bit.
REQ-032 SHALL contain no latches; next-state and excitation logic SHALL be purely combinational.

Verification
REQ-033 SHALL cover up-count wrap: reset, mod_n=10, up=1, en=1 for 12 cycles -> q = 1..9,0,1,2; tc high only on the cycle where q = 0.
REQ-034 SHALL cover down-count wrap: mod_n=6, load 0, then up=0, en=1 for 3 cycles -> q = 5,4,3; tc high with q = 5.
REQ-035 SHALL cover load handling: mod_n=10, load=1 with load_val=7 -> q = 7, err = 0. Then load_val=12 -> q = 0, err = 1 for one cycle. Then load with en=1 asserted together -> load wins.
REQ-036 SHALL cover full-range mode: mod_n=0, q = 15, up count -> q = 0, tc = 1. Excitation checks: at q=15 going to 0, j_out = 0000 and k_out = 1111; at q=0 going to 15, j_out = 1111 and k_out = 0000.
REQ-037 SHALL cover reset mid-count: reset asserted at q = 6 with en = 1 -> q = 0 and tc = err = 0 next edge; after release, q = 1.
REQ-038 SHALL cover modulus shrink: q = 8, mod_n changed to 5, up=1 -> q = 0 with tc = 1. With up=0 instead -> q = 4 with tc = 1.
